lif_layer_net: RTL and testbench
================================

# lif_layer_net

Parametrised two-layer leaky integrate-and-fire network: N_IN hidden LIF neurons, each driven by its own multi-bit input current, feed a registered weighted spike sum into one output LIF neuron. Adds programmable thresholds, per-channel weights via a config write port, refractory periods, an enable-gated update and a saturating output spike counter. Sits between the input switch/current front end and the spike display/readout logic.

## Interface
- N_IN, 8: number of hidden neurons / input channels (1..16).
- W, 8: membrane, current, weight and threshold width in bits.
- LEAK_SHIFT, 1: leak per update is V >> LEAK_SHIFT (0 = full discharge each update).
- REFRAC, 2: refractory updates after a spike (0 = none).
- CNT_W, 16: output spike counter width.

- clk  in  1  clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- ena  in  1  update enable; low freezes all neuron, sum and counter state.
- current  in  N_IN*W  channel i current at bits [i*W +: W], unsigned.
- thr_hidden  in  W  threshold shared by all hidden neurons.
- thr_out  in  W  output neuron threshold.
- cfg_we  in  1  weight write strobe.
- cfg_addr  in  4  weight index; ≥ N_IN ignored.
- cfg_data  in  W  weight value, unsigned.
- hidden_spikes  out  N_IN  registered hidden spike vector.
- spike_out  out  1  registered output neuron spike.
- state_out  out  W  output neuron membrane.
- spike_count  out  CNT_W  count of output spikes, saturating.

## Operation
- Neuron rule (hidden and output identical, evaluated on each clk edge with ena=1):
  - If refractory counter r > 0: V <= 0, r <= r-1, spike <= 0.
  - Else Vn = V - (V >> LEAK_SHIFT) + I, computed at W+1 bits, saturated to 2^W-1.
  - Vn ≥ thr: spike <= 1, V <= 0, r <= REFRAC. Else spike <= 0, V <= Vn.
  - thr = 0 → spikes on every non-refractory update.
- Hidden neuron i: I = current channel i.
- Sum register: sum <= Σ (hidden_spikes[i] ? weight[i] : 0), width W+clog2(N_IN), no overflow; output neuron I = min(sum, 2^W-1).
- Weights: N_IN registers, reset value 1 (unit-weight spike count). cfg_we=1 with cfg_addr < N_IN writes cfg_data at the edge; accepted regardless of ena.
- spike_count increments on each edge where spike_out is updated to 1; holds at 2^CNT_W-1.
- ena=0: V, r, spikes, sum, spike_count all hold; outputs stable.

## Timing
- Reset (async assert, sync-safe deassert by clk): all V, r, sum, hidden_spikes, spike_out, state_out, spike_count = 0; weights = 1. Outputs go to reset values without a clock edge.
- Reset mid-operation: pending refractory and membranes discarded; first update after release starts from V=0.
- Latency: current sampled at edge k → hidden_spikes at edge k; sum at k+1; spike_out/state_out at k+2.
- Weight write at edge k: sum at edge k uses old weight; new weight used from edge k+1.
- Spike pulses are one cycle wide (neuron resets to 0 and enters refractory).
- Simultaneous cfg_we and ena=0: write still occurs.

## Test plan
- W=8, thr_hidden=100, LEAK_SHIFT=1, REFRAC=2, channel 0 current=60 constant -> V0 = 60, 90, then spike on 3rd update (105), V held 0 for 2 updates, then 60; spikes every 5 updates.
- Channel 0 current=200, thr_hidden=255 -> 1st update V=200 no spike; 2nd Vn=300 saturates to 255 -> spike.
- All weights written 40, all 8 channels spike at edge k, thr_out=250 -> sum=320 at k+1, clamped 255 into output -> spike_out=1 at k+2, spike_count=1.
- Default weights, 3 hidden spikes at edge k -> sum=3; ena=0 for 4 cycles -> all outputs frozen; ena=1 resumes exactly where stopped.
- Assert rst_n low mid-refractory with spike_count=5 -> all outputs 0 immediately, weights read back as 1 (unit-weight sum), counter 0.
- cfg_we with cfg_addr=N_IN (8) data=200 -> no weight changes; CNT_W=4, 20 output spikes -> spike_count holds at 15.

Source files
------------

// File: rtl/lif_layer_net_if.sv
// Stimulus/config/readout bundle for the two-layer LIF network.
interface lif_layer_net_if #(
    parameter int unsigned N_IN  = 8,
    parameter int unsigned W     = 8,
    parameter int unsigned CNT_W = 16
);
    logic                 ena;
    logic [N_IN*W-1:0]    current;
    logic [W-1:0]         thr_hidden;
    logic [W-1:0]         thr_out;
    logic                 cfg_we;
    logic [3:0]           cfg_addr;
    logic [W-1:0]         cfg_data;
    logic [N_IN-1:0]      hidden_spikes;
    logic                 spike_out;
    logic [W-1:0]         state_out;
    logic [CNT_W-1:0]     spike_count;

    modport master (
        output ena, current, thr_hidden, thr_out, cfg_we, cfg_addr, cfg_data,
        input  hidden_spikes, spike_out, state_out, spike_count
    );

    modport slave (
        input  ena, current, thr_hidden, thr_out, cfg_we, cfg_addr, cfg_data,
        output hidden_spikes, spike_out, state_out, spike_count
    );
endinterface

// File: rtl/lif_layer_net.sv
// N_IN hidden LIF neurons -> registered weighted spike sum -> one output LIF neuron
// with refractory periods, programmable thresholds/weights and a saturating spike counter.
module lif_layer_net #(
    parameter int unsigned N_IN       = 8,
    parameter int unsigned W          = 8,
    parameter int unsigned LEAK_SHIFT = 1,
    parameter int unsigned REFRAC     = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    lif_layer_net_if.slave   bus
);
    localparam int unsigned RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    localparam int unsigned SW = W + $clog2(N_IN);
    localparam logic [W-1:0]  V_MAX  = '1;
    localparam logic [RW-1:0] R_LOAD = RW'(REFRAC);

    // One neuron update: leak, integrate with saturation, fire/reset, refractory hold.
    function automatic void neuron_step(
        input  logic [W-1:0]  v,
        input  logic [RW-1:0] r,
        input  logic [W-1:0]  i,
        input  logic [W-1:0]  thr,
        output logic [W-1:0]  v_n,
        output logic [RW-1:0] r_n,
        output logic          s_n
    );
        logic [W:0]   acc;
        logic [W-1:0] sat;
        acc = {1'b0, v} - ({1'b0, v} >> LEAK_SHIFT) + {1'b0, i};
        sat = acc[W] ? V_MAX : acc[W-1:0];
        v_n = sat;
        r_n = r;
        s_n = 1'b0;
        if (r != '0) begin
            v_n = '0;
            r_n = r - RW'(1);
        end else if (sat >= thr) begin
            v_n = '0;
            r_n = R_LOAD;
            s_n = 1'b1;
        end
    endfunction

    logic [W-1:0]     v_h   [N_IN];
    logic [RW-1:0]    r_h   [N_IN];
    logic [W-1:0]     v_h_d [N_IN];
    logic [RW-1:0]    r_h_d [N_IN];
    logic [W-1:0]     weight[N_IN];
    logic [N_IN-1:0]  hs_q, hs_d;
    logic [SW-1:0]    sum_q, sum_d;
    logic [W-1:0]     i_o;
    logic [W-1:0]     v_o, v_o_d;
    logic [RW-1:0]    r_o, r_o_d;
    logic             spk_q, spk_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Hidden layer next state.
    always_comb begin
        hs_d = '0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            v_h_d[i] = '0;
            r_h_d[i] = '0;
            neuron_step(v_h[i], r_h[i], bus.current[i*W +: W], bus.thr_hidden,
                        v_h_d[i], r_h_d[i], hs_d[i]);
        end
    end

    // Weighted sum of the registered spike vector, clamp, output neuron, counter.
    always_comb begin
        sum_d = '0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            if (hs_q[i]) sum_d = sum_d + SW'(weight[i]);
        end
        i_o   = (sum_q > SW'(V_MAX)) ? V_MAX : sum_q[W-1:0];
        v_o_d = '0;
        r_o_d = '0;
        spk_d = 1'b0;
        neuron_step(v_o, r_o, i_o, bus.thr_out, v_o_d, r_o_d, spk_d);
        cnt_d = (spk_d && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_IN; i++) begin
                v_h[i] <= '0;
                r_h[i] <= '0;
            end
            hs_q  <= '0;
            sum_q <= '0;
            v_o   <= '0;
            r_o   <= '0;
            spk_q <= 1'b0;
            cnt_q <= '0;
        end else if (bus.ena) begin
            for (int unsigned i = 0; i < N_IN; i++) begin
                v_h[i] <= v_h_d[i];
                r_h[i] <= r_h_d[i];
            end
            hs_q  <= hs_d;
            sum_q <= sum_d;
            v_o   <= v_o_d;
            r_o   <= r_o_d;
            spk_q <= spk_d;
            cnt_q <= cnt_d;
        end
    end

    // Weight file is written independently of ena; out-of-range addresses match nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_IN; i++) weight[i] <= W'(1);
        end else begin
            for (int unsigned i = 0; i < N_IN; i++) begin
                if (bus.cfg_we && (32'(bus.cfg_addr) == i)) weight[i] <= bus.cfg_data;
            end
        end
    end

    assign bus.hidden_spikes = hs_q;
    assign bus.spike_out     = spk_q;
    assign bus.state_out     = v_o;
    assign bus.spike_count   = cnt_q;
endmodule

// File: tb/tb_lif_layer_net.sv
// Directed bench for lif_layer_net: per-cycle vector table plus hand-written corner sequences.
module tb_lif_layer_net;
    localparam int unsigned N_IN = 8;
    localparam int unsigned W    = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lif_layer_net_if #(.N_IN(8), .W(8), .CNT_W(16)) bus  ();
    lif_layer_net_if #(.N_IN(8), .W(8), .CNT_W(4))  bus4 ();

    lif_layer_net #(.N_IN(8), .W(8), .LEAK_SHIFT(1), .REFRAC(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
    lif_layer_net #(.N_IN(8), .W(8), .LEAK_SHIFT(1), .REFRAC(0), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4));

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic       do_rst;
        logic [7:0] cur0;
        logic [7:0] thr_h;
        logic [7:0] exp_hs;
        logic [7:0] exp_st;
        logic       exp_spk;
    } vec_t;

    vec_t tbl [17];

    initial begin
        // channel 0 = 60, thr 100: spikes on updates 3, 8, 13; sum feeds output two edges later
        tbl[0]  = '{1'b1, 8'd60,  8'd100, 8'h00, 8'd0, 1'b0};
        tbl[1]  = '{1'b0, 8'd60,  8'd100, 8'h00, 8'd0, 1'b0};
        tbl[2]  = '{1'b0, 8'd60,  8'd100, 8'h01, 8'd0, 1'b0};
        tbl[3]  = '{1'b0, 8'd60,  8'd100, 8'h00, 8'd0, 1'b0};
        tbl[4]  = '{1'b0, 8'd60,  8'd100, 8'h00, 8'd1, 1'b0};
        tbl[5]  = '{1'b0, 8'd60,  8'd100, 8'h00, 8'd1, 1'b0};
        tbl[6]  = '{1'b0, 8'd60,  8'd100, 8'h00, 8'd1, 1'b0};
        tbl[7]  = '{1'b0, 8'd60,  8'd100, 8'h01, 8'd1, 1'b0};
        tbl[8]  = '{1'b0, 8'd60,  8'd100, 8'h00, 8'd1, 1'b0};
        tbl[9]  = '{1'b0, 8'd60,  8'd100, 8'h00, 8'd2, 1'b0};
        tbl[10] = '{1'b0, 8'd60,  8'd100, 8'h00, 8'd1, 1'b0};
        tbl[11] = '{1'b0, 8'd60,  8'd100, 8'h00, 8'd1, 1'b0};
        tbl[12] = '{1'b0, 8'd60,  8'd100, 8'h01, 8'd1, 1'b0};
        // channel 0 = 200, thr 255: 200 then 300 saturates to 255 and fires
        tbl[13] = '{1'b1, 8'd200, 8'd255, 8'h00, 8'd0, 1'b0};
        tbl[14] = '{1'b0, 8'd200, 8'd255, 8'h01, 8'd0, 1'b0};
        tbl[15] = '{1'b0, 8'd200, 8'd255, 8'h00, 8'd0, 1'b0};
        tbl[16] = '{1'b0, 8'd200, 8'd255, 8'h00, 8'd1, 1'b0};

        bus.ena = 1'b0; bus.current = '0; bus.thr_hidden = 8'd100; bus.thr_out = 8'd200;
        bus.cfg_we = 1'b0; bus.cfg_addr = 4'd0; bus.cfg_data = 8'd0;
        bus4.ena = 1'b0; bus4.current = '0; bus4.thr_hidden = 8'd0; bus4.thr_out = 8'd0;
        bus4.cfg_we = 1'b0; bus4.cfg_addr = 4'd0; bus4.cfg_data = 8'd0;

        // Reset state
        #3;
        check("rst hs",     32'(bus.hidden_spikes), 32'd0);
        check("rst spk",    32'(bus.spike_out),     32'd0);
        check("rst state",  32'(bus.state_out),     32'd0);
        check("rst cnt",    32'(bus.spike_count),   32'd0);
        check("rst cnt4",   32'(bus4.spike_count),  32'd0);
        #3;
        rst_n = 1'b1;

        // Table-driven per-cycle vectors
        bus.thr_out = 8'd200;
        for (int k = 0; k < 17; k++) begin
            if (tbl[k].do_rst) do_reset();
            bus.ena        = 1'b1;
            bus.current    = '0;
            bus.current[7:0] = tbl[k].cur0;
            bus.thr_hidden = tbl[k].thr_h;
            tick();
            check($sformatf("vec%0d hs", k),    32'(bus.hidden_spikes), 32'(tbl[k].exp_hs));
            check($sformatf("vec%0d state", k), 32'(bus.state_out),     32'(tbl[k].exp_st));
            check($sformatf("vec%0d spk", k),   32'(bus.spike_out),     32'(tbl[k].exp_spk));
        end

        // Enable freeze: three unit-weight spikes held across 4 disabled cycles
        do_reset();
        bus.thr_hidden = 8'd100; bus.thr_out = 8'd200;
        bus.current = '0; bus.current[23:0] = {3{8'd100}};
        bus.ena = 1'b1;
        tick();
        check("frz hs k", 32'(bus.hidden_spikes), 32'h07);
        bus.ena = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("frz%0d hs", c),    32'(bus.hidden_spikes), 32'h07);
            check($sformatf("frz%0d state", c), 32'(bus.state_out),     32'd0);
            check($sformatf("frz%0d spk", c),   32'(bus.spike_out),     32'd0);
        end
        bus.ena = 1'b1;
        tick();
        check("res hs k+1",    32'(bus.hidden_spikes), 32'h00);
        tick();
        check("res state k+2", 32'(bus.state_out),     32'd3);
        check("res hs k+2",    32'(bus.hidden_spikes), 32'h00);
        tick();
        check("res hs k+3",    32'(bus.hidden_spikes), 32'h07);
        check("res state k+3", 32'(bus.state_out),     32'd2);

        // Weights 40 written while disabled; sum 320 clamps to 255 and fires output
        do_reset();
        bus.ena = 1'b0; bus.thr_hidden = 8'd100; bus.current = {8{8'd100}}; bus.thr_out = 8'd250;
        for (int a = 0; a < 8; a++) begin
            bus.cfg_we = 1'b1; bus.cfg_addr = 4'(a); bus.cfg_data = 8'd40;
            tick();
        end
        bus.cfg_we = 1'b0;
        check("w40 frozen hs", 32'(bus.hidden_spikes), 32'h00);
        bus.ena = 1'b1;
        tick();
        check("w40 hs k",     32'(bus.hidden_spikes), 32'hFF);
        check("w40 spk k",    32'(bus.spike_out),     32'd0);
        tick();
        check("w40 spk k+1",  32'(bus.spike_out),     32'd0);
        tick();
        check("w40 spk k+2",  32'(bus.spike_out),     32'd1);
        check("w40 state",    32'(bus.state_out),     32'd0);
        check("w40 cnt",      32'(bus.spike_count),   32'd1);
        bus.ena = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            check($sformatf("w40 hold%0d spk", c), 32'(bus.spike_out),   32'd1);
            check($sformatf("w40 hold%0d cnt", c), 32'(bus.spike_count), 32'd1);
        end

        // Reset restores unit weights; address 8 ignored; write timing old/new weight
        do_reset();
        bus.ena = 1'b0;
        bus.cfg_we = 1'b1; bus.cfg_addr = 4'd8; bus.cfg_data = 8'd200;
        tick();
        bus.cfg_we = 1'b0;
        bus.thr_hidden = 8'd100; bus.current = {8{8'd100}}; bus.thr_out = 8'd250;
        bus.ena = 1'b1;
        tick();
        check("wr hs e1", 32'(bus.hidden_spikes), 32'hFF);
        bus.cfg_we = 1'b1; bus.cfg_addr = 4'd0; bus.cfg_data = 8'd100;
        tick();
        bus.cfg_we = 1'b0;
        tick();
        check("wr unit sum state", 32'(bus.state_out), 32'd8);
        tick();
        tick();
        tick();
        check("wr new weight state", 32'(bus.state_out), 32'd108);
        check("wr new weight spk",   32'(bus.spike_out), 32'd0);

        // Reset mid-refractory with count 5
        do_reset();
        bus.ena = 1'b1; bus.thr_hidden = 8'd0; bus.thr_out = 8'd0; bus.current = '0;
        repeat (13) tick();
        check("mid cnt5",  32'(bus.spike_count),   32'd5);
        check("mid hs",    32'(bus.hidden_spikes), 32'hFF);
        check("mid spk",   32'(bus.spike_out),     32'd1);
        rst_n = 1'b0;
        #1;
        check("async hs",    32'(bus.hidden_spikes), 32'd0);
        check("async spk",   32'(bus.spike_out),     32'd0);
        check("async state", 32'(bus.state_out),     32'd0);
        check("async cnt",   32'(bus.spike_count),   32'd0);
        rst_n = 1'b1;
        tick();
        check("post hs",  32'(bus.hidden_spikes), 32'hFF);
        check("post spk", 32'(bus.spike_out),     32'd1);
        check("post cnt", 32'(bus.spike_count),   32'd1);

        // 4-bit counter saturation (no refractory, thr 0 -> fires every update)
        bus.ena = 1'b0;
        bus4.ena = 1'b1;
        repeat (15) tick();
        check("cnt4 at 15",  32'(bus4.spike_count), 32'd15);
        check("cnt4 spk",    32'(bus4.spike_out),   32'd1);
        repeat (5) tick();
        check("cnt4 sat",    32'(bus4.spike_count), 32'd15);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
